pc_fetch_ctrl: RTL and testbench

//  Owns the architectural PC register and sequences instruction fetch for the MIPS core.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/sat_counter.sv | 13 +
 rtl/pc_fetch_ctrl.sv | 79 +++++++
 tb/tb_pc_fetch_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch FSM state encoding and the reset and exception vectors.
package fetch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    VALID = 2'b10
  } state_t;
  localparam logic [29:0] FETCH_RESET_PC = 30'h0C00;
  localparam logic [29:0] FETCH_EXC_PC   = 30'h0C20;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC and runs the imem req/ack and decode valid/ready fetch loop.
// Define FETCH_PERF_EN to add saturating retire/wait performance counters.
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [29:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [29:0] EXC_PC   = FETCH_EXC_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic [29:0]      npc_in,
  output logic [29:0]      pc_q,
  output logic             imem_req,
  output logic [29:0]      imem_addr,
  input  logic             imem_ack,
  input  logic             imem_err,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  input  logic             if_ready,
`ifdef FETCH_PERF_EN
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] wait_cnt,
`endif
  output logic             exc_pulse
);
  state_t state;
  assign imem_addr = pc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      if_instr  <= '0;
      imem_req  <= 1'b0;
      if_valid  <= 1'b0;
      exc_pulse <= 1'b0;
    end else begin
      exc_pulse <= 1'b0;
      case (state)
        IDLE:
          if (!halt) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        REQ:
          if (imem_ack && imem_err) begin
            pc_q      <= EXC_PC;
            exc_pulse <= 1'b1;
          end else if (imem_ack) begin
            if_instr <= imem_rdata;
            state    <= VALID;
            imem_req <= 1'b0;
            if_valid <= 1'b1;
          end
        VALID:
          if (if_ready) begin
            pc_q     <= npc_in;
            state    <= halt ? IDLE : REQ;
            imem_req <= !halt;
            if_valid <= 1'b0;
          end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          if_valid <= 1'b0;
        end
      endcase
    end
`ifdef FETCH_PERF_EN
  sat_counter #(.W(CNT_W)) u_retire (
    .clk(clk), .rst_n(rst_n), .inc(state == VALID && if_ready), .count(retire_cnt)
  );
  sat_counter #(.W(CNT_W)) u_wait (
    .clk(clk), .rst_n(rst_n), .inc(state == REQ && !imem_ack), .count(wait_cnt)
  );
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table plus hand sequences for reset-in-REQ and halt.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic [29:0] npc_in = '0;
  logic [29:0] pc_q, imem_addr;
  logic        imem_req, imem_ack = 1'b0, imem_err = 1'b0;
  logic [31:0] imem_rdata = '0, if_instr;
  logic        if_valid, if_ready = 1'b0, exc_pulse;
`ifdef FETCH_PERF_EN
  logic [31:0] retire_cnt, wait_cnt;
`endif
  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  int exp_wait = 0;
  logic prev_req = 1'b0;
  logic prev_val = 1'b0;
  always #5 clk = ~clk;
  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .npc_in(npc_in), .pc_q(pc_q),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_err(imem_err),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
`ifdef FETCH_PERF_EN
    .retire_cnt(retire_cnt), .wait_cnt(wait_cnt),
`endif
    .exc_pulse(exc_pulse)
  );
  typedef struct {
    logic        h, a, e;
    logic [31:0] rd;
    logic        r;
    logic [29:0] npc;
    logic        x_req, x_val, x_exc;
    logic [29:0] x_pc;
    logic [31:0] x_ins;
  } vec_t;
  vec_t v [20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic rq, input logic vl, input logic ex,
                         input logic [29:0] pc, input logic [31:0] ins);
    chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, rq});
    chk({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, vl});
    chk({tag, " exc_pulse"}, {31'd0, exc_pulse}, {31'd0, ex});
    chk({tag, " pc_q"}, {2'd0, pc_q}, {2'd0, pc});
    chk({tag, " imem_addr"}, {2'd0, imem_addr}, {2'd0, pc});
    chk({tag, " if_instr"}, if_instr, ins);
  endtask
  task automatic step(input logic h, input logic a, input logic e, input logic [31:0] rd,
                      input logic r, input logic [29:0] npc);
    @(negedge clk);
    halt = h; imem_ack = a; imem_err = e; imem_rdata = rd; if_ready = r; npc_in = npc;
    exp_ret  += (prev_val && r) ? 1 : 0;
    exp_wait += (prev_req && !a) ? 1 : 0;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt(input string tag);
`ifdef FETCH_PERF_EN
    chk({tag, " retire_cnt"}, retire_cnt, exp_ret);
    chk({tag, " wait_cnt"}, wait_cnt, exp_wait);
`else
    checks += 0;
`endif
  endtask
  initial begin
    //        h     a     e     rdata          r     npc           req   val   exc   pc            instr
    v[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 30'h0,        1'b1, 1'b0, 1'b0, 30'h0C00,     32'h0};
    v[1]  = '{1'b0, 1'b1, 1'b0, 32'h2008_0005, 1'b0, 30'h0,        1'b0, 1'b1, 1'b0, 30'h0C00,     32'h2008_0005};
    v[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 30'h0C01,     1'b1, 1'b0, 1'b0, 30'h0C01,     32'h2008_0005};
    v[3]  = '{1'b0, 1'b1, 1'b0, 32'h8C09_0004, 1'b0, 30'h0,        1'b0, 1'b1, 1'b0, 30'h0C01,     32'h8C09_0004};
    v[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 30'h0DEA,     1'b0, 1'b1, 1'b0, 30'h0C01,     32'h8C09_0004};
    v[5]  = '{1'b0, 1'b1, 1'b0, 32'hAAAA_AAAA, 1'b0, 30'h0DEA,     1'b0, 1'b1, 1'b0, 30'h0C01,     32'h8C09_0004};
    v[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 30'h0DEA,     1'b0, 1'b1, 1'b0, 30'h0C01,     32'h8C09_0004};
    v[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 30'h0DEA,     1'b0, 1'b1, 1'b0, 30'h0C01,     32'h8C09_0004};
    v[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 30'h0C05,     1'b1, 1'b0, 1'b0, 30'h0C05,     32'h8C09_0004};
    v[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 30'h0,        1'b1, 1'b0, 1'b0, 30'h0C05,     32'h8C09_0004};
    v[10] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 30'h0,        1'b1, 1'b0, 1'b1, 30'h0C20,     32'h8C09_0004};
    v[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 30'h0,        1'b1, 1'b0, 1'b0, 30'h0C20,     32'h8C09_0004};
    v[12] = '{1'b0, 1'b1, 1'b0, 32'h3C01_0001, 1'b0, 30'h0,        1'b0, 1'b1, 1'b0, 30'h0C20,     32'h3C01_0001};
    v[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 30'h0C21,     1'b0, 1'b0, 1'b0, 30'h0C21,     32'h3C01_0001};
    v[14] = '{1'b1, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 30'h0,        1'b0, 1'b0, 1'b0, 30'h0C21,     32'h3C01_0001};
    v[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 30'h0,        1'b1, 1'b0, 1'b0, 30'h0C21,     32'h3C01_0001};
    v[16] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 30'h0,        1'b0, 1'b1, 1'b0, 30'h0C21,     32'h0};
    v[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 30'h3FFF_FFFF, 1'b1, 1'b0, 1'b0, 30'h3FFF_FFFF, 32'h0};
    v[18] = '{1'b0, 1'b1, 1'b0, 32'h1111_2222, 1'b0, 30'h0,        1'b0, 1'b1, 1'b0, 30'h3FFF_FFFF, 32'h1111_2222};
    v[19] = '{1'b0, 1'b1, 1'b0, 32'h3333_4444, 1'b0, 30'h0,        1'b0, 1'b1, 1'b0, 30'h3FFF_FFFF, 32'h1111_2222};
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 30'h0C00, 32'h0);
    chk_cnt("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(v[i].h, v[i].a, v[i].e, v[i].rd, v[i].r, v[i].npc);
      chk_out($sformatf("vec%0d", i), v[i].x_req, v[i].x_val, v[i].x_exc, v[i].x_pc, v[i].x_ins);
      prev_req = v[i].x_req;
      prev_val = v[i].x_val;
    end
    chk_cnt("vectors");
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 30'h0C30);
    chk_out("rst_seq accept", 1'b1, 1'b0, 1'b0, 30'h0C30, 32'h1111_2222);
    prev_req = 1'b1; prev_val = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 30'h0);
    chk_out("rst_seq wait", 1'b1, 1'b0, 1'b0, 30'h0C30, 32'h1111_2222);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_ret = 0; exp_wait = 0; prev_req = 1'b0; prev_val = 1'b0;
    chk_out("rst_seq async", 1'b0, 1'b0, 1'b0, 30'h0C00, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk_out("rst_seq held", 1'b0, 1'b0, 1'b0, 30'h0C00, 32'h0);
    chk_cnt("rst_seq held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("rst_seq stray", 1'b1, 1'b0, 1'b0, 30'h0C00, 32'h0);
    prev_req = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 30'h0);
    chk_out("rst_seq delay", 1'b1, 1'b0, 1'b0, 30'h0C00, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 30'h0);
    chk_out("rst_seq refetch", 1'b0, 1'b1, 1'b0, 30'h0C00, 32'h1234_5678);
    prev_req = 1'b0; prev_val = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 30'h0C40);
    chk_out("halt idle", 1'b0, 1'b0, 1'b0, 30'h0C40, 32'h1234_5678);
    prev_val = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 30'h0);
    chk_out("halt hold", 1'b0, 1'b0, 1'b0, 30'h0C40, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 30'h0);
    chk_out("halt release", 1'b1, 1'b0, 1'b0, 30'h0C40, 32'h1234_5678);
    chk_cnt("halt");
`ifdef FETCH_PERF_EN
    chk("retire one", retire_cnt, 32'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
